// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit
// One shift-add or restoring-subtract step per cycle, fixed WIDTH+1 cycle latency.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [2:0]       MDOp,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] MDResult
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   logic [2:0]         op;
   logic [WIDTH-1:0]   opb;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               neg_main;
   logic               neg_rem;

   logic               accept;
   logic               sign_a, sign_b, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, div_shift, div_next, acc_next, prod;
   logic [WIDTH:0]     div_diff;
   logic [WIDTH-1:0]   quot, rem, result;

   // Operand conditioning at the accept edge: only signed operands are folded to magnitudes.
   always_comb begin
      accept = Start && (state != CALC);
      sign_a = (MDOp != 3'b011) && (MDOp != 3'b101) && (MDOp != 3'b111);
      sign_b = sign_a && (MDOp != 3'b010);
      a_neg  = sign_a && SrcA[WIDTH-1];
      b_neg  = sign_b && SrcB[WIDTH-1];
      a_mag  = a_neg ? (~SrcA + 1'b1) : SrcA;
      b_mag  = b_neg ? (~SrcB + 1'b1) : SrcB;
   end

   // Multiply keeps {product_hi, multiplier}; divide keeps {remainder, quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-2:0], 1'b0};
      div_diff  = {acc[2*WIDTH-1], div_shift[2*WIDTH-1:WIDTH]} - {1'b0, opb};
      div_next  = div_diff[WIDTH] ? div_shift
                                  : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
      acc_next  = op[2] ? div_next : mul_next;
   end

   // Final fix-up, applied to the value the last step produces.
   always_comb begin
      prod = neg_main ? (~acc_next + 1'b1) : acc_next;
      quot = neg_main ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
      rem  = neg_rem ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1) : acc_next[2*WIDTH-1:WIDTH];
      case (op)
         3'b000:                 result = prod[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: result = prod[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         result = quot;
         default:                result = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         MDResult <= '0;
         cnt      <= '0;
         op       <= '0;
         opb      <= '0;
         acc      <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state    <= CALC;
                  Busy     <= 1'b1;
                  cnt      <= '0;
                  op       <= MDOp;
                  opb      <= MDOp[2] ? b_mag : a_mag;
                  acc      <= {{WIDTH{1'b0}}, (MDOp[2] ? a_mag : b_mag)};
                  // Divide by zero must return an all-ones quotient even for a negative dividend.
                  neg_main <= (MDOp[2] && (SrcB == '0)) ? 1'b0 : (a_neg ^ b_neg);
                  neg_rem  <= a_neg;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state    <= DONE;
                  Busy     <= 1'b0;
                  Done     <= 1'b1;
                  MDResult <= result;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Directed vector table, hand-written protocol sequences, then random ops against a 64-bit arithmetic model.
module tb_muldiv_unit;

   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              Start = 1'b0;
   logic [2:0]        MDOp = '0;
   logic [WIDTH-1:0]  SrcA = '0;
   logic [WIDTH-1:0]  SrcB = '0;
   logic              Busy;
   logic              Done;
   logic [WIDTH-1:0]  MDResult;

   int errors = 0;
   int checks = 0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
      .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .MDResult(MDResult)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint          ub = longint'({32'h0, b});
      longint          p;
      longint unsigned pu;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   // Called 1ns after an edge; the following edge accepts the request.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
      @(posedge clk); #1;
      Start = 1'b0;
   endtask

   // n = edges after the accept edge until Done is seen; busy_cnt = cycles with Busy=1 before that.
   task automatic wait_done(input string name, output int n, output int busy_cnt);
      n = 0;
      busy_cnt = 0;
      while (1) begin
         if (Busy) busy_cnt++;
         @(posedge clk); #1;
         n++;
         if (Done) break;
         if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no Done after %0d cycles, expected %0d", name, n, WIDTH);
            break;
         end
      end
   endtask

   initial begin
      int n, bc;
      logic [31:0] r1;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [31:0] specials[6];
      bit          seen_done;

      specials[0] = 32'h0;          specials[1] = 32'hFFFFFFFF;
      specials[2] = 32'h80000000;   specials[3] = 32'h1;
      specials[4] = 32'h7FFFFFFF;   specials[5] = 32'h2;

      vecs[0]  = '{"mul_7_m3",        3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
      vecs[1]  = '{"mulhu_m1_m1",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[2]  = '{"mulhsu_m1_m1",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[3]  = '{"mulh_m1_m1",      3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vecs[4]  = '{"div_m7_2",        3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
      vecs[5]  = '{"rem_m7_2",        3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
      vecs[6]  = '{"divu_100_7",      3'd5, 32'd100,      32'd7,        32'd14};
      vecs[7]  = '{"div_5_0",         3'd4, 32'd5,        32'd0,        32'hFFFFFFFF};
      vecs[8]  = '{"remu_5_0",        3'd7, 32'd5,        32'd0,        32'd5};
      vecs[9]  = '{"div_ovf",         3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      vecs[10] = '{"rem_ovf",         3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
      vecs[11] = '{"div_m7_0",        3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
      vecs[12] = '{"rem_m7_0",        3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_done", {31'd0, Done}, 32'd0);
      chk("reset_result", MDResult, 32'd0);

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(vecs[i].name, n, bc);
         chk({vecs[i].name, "_result"}, MDResult, vecs[i].exp);
         chk({vecs[i].name, "_latency"}, n, WIDTH);
         chk({vecs[i].name, "_busy_cycles"}, bc, WIDTH);
         @(posedge clk); #1;
         chk({vecs[i].name, "_done_pulse"}, {31'd0, Done}, 32'd0);
         chk({vecs[i].name, "_held"}, MDResult, vecs[i].exp);
      end

      // Start during CALC must not disturb the operation in flight.
      issue(3'd0, 32'd7, 32'hFFFFFFFD);
      repeat (9) @(posedge clk);
      #1;
      Start = 1'b1; MDOp = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
      @(posedge clk); #1;
      Start = 1'b0;
      wait_done("ignore_start", n, bc);
      chk("ignore_start_result", MDResult, 32'hFFFFFFEB);
      chk("ignore_start_latency", n + 10, WIDTH);
      seen_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (Done || Busy) seen_done = 1;
      end
      chk("ignore_start_no_second", {31'd0, seen_done}, 32'd0);

      // Back-to-back: new Start in the DONE cycle.
      issue(3'd5, 32'd100, 32'd7);
      wait_done("b2b_first", n, bc);
      chk("b2b_first_result", MDResult, 32'd14);
      issue(3'd4, 32'hFFFFFFF9, 32'd2);
      chk("b2b_busy_after_accept", {31'd0, Busy}, 32'd1);
      wait_done("b2b_second", n, bc);
      chk("b2b_second_latency", n, WIDTH);
      chk("b2b_second_result", MDResult, 32'hFFFFFFFD);
      @(posedge clk); #1;

      // Reset mid-operation at iteration 10.
      issue(3'd6, 32'hFFFFFFF9, 32'd2);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("midreset_busy", {31'd0, Busy}, 32'd0);
      chk("midreset_done", {31'd0, Done}, 32'd0);
      chk("midreset_result", MDResult, 32'd0);
      seen_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (Done) seen_done = 1;
      end
      chk("midreset_no_done", {31'd0, seen_done}, 32'd0);

      // Random ops, operands biased toward boundary values.
      for (int k = 0; k < 200; k++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         issue(rop, ra, rb);
         wait_done("random", n, bc);
         r1 = model(rop, ra, rb);
         checks++;
         if (MDResult !== r1 || n != WIDTH) begin
            errors++;
            $display("FAIL random op=%0d a=0x%08h b=0x%08h: got 0x%08h after %0d cycles expected 0x%08h after %0d",
                     rop, ra, rb, MDResult, n, r1, WIDTH);
         end
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
